// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Fetches one instruction word at a time from instruction memory, holds it
// for the execute stage until it is retired, then advances the program
// counter from the decoder-selected next-PC source.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no request outstanding, no instruction held; waits for enable
//   ST_FETCH | read request to imem at pc, waiting for imem_ready
//   ST_ISSUE | instruction captured and valid, waiting for instr_done
//
// All outputs except opcode come straight from flops. The request address is
// loaded together with the request itself, so imem_addr always equals pc
// whenever imem_req is high.

module pc_fetch_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_enable,
    output logic        imem_req,
    output logic [11:0] imem_addr,
    input  logic        imem_ready,
    input  logic [18:0] imem_rdata,
    output logic [18:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        instr_done,
    input  logic        sel_PCSrc_plus1,
    input  logic        sel_PCSrc_offset,
    input  logic        sel_PCSrc_const,
    input  logic        branch_taken,
    output logic [11:0] pc,
    output logic        pc_sel_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_ISSUE = 2'b10
    } state_t;

    state_t      state_q;
    logic [11:0] pc_q;
    logic [18:0] instr_q;
    logic        instr_valid_q;
    logic        imem_req_q;
    logic [11:0] imem_addr_q;
    logic        pc_sel_err_q;

    logic [11:0] pc_plus1;
    logic [11:0] branch_off;
    logic [11:0] next_pc_d;
    logic        sel_bad_d;
    logic        retire;

    assign retire = (state_q == ST_ISSUE) && instr_done;

    // Next-PC candidates; 12-bit adders wrap naturally modulo 4096.
    assign pc_plus1   = pc_q + 12'd1;
    assign branch_off = {{4{instr_q[7]}}, instr_q[7:0]};

    // Next-PC mux; anything other than exactly one select falls back to pc+1
    // and is flagged as an illegal selection.
    always_comb begin
        next_pc_d = pc_plus1;
        sel_bad_d = 1'b0;
        case ({sel_PCSrc_plus1, sel_PCSrc_offset, sel_PCSrc_const})
            3'b100: next_pc_d = pc_plus1;
            3'b010: next_pc_d = branch_taken ? (pc_plus1 + branch_off) : pc_plus1;
            3'b001: next_pc_d = instr_q[11:0];
            default: begin
                next_pc_d = pc_plus1;
                sel_bad_d = 1'b1;
            end
        endcase
    end

    // Fetch/issue sequencer with registered memory request and issue outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= 12'd0;
            instr_q       <= 19'd0;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= 12'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    instr_valid_q <= 1'b0;
                    if (fetch_enable) begin
                        state_q     <= ST_FETCH;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= pc_q;
                    end else begin
                        imem_req_q  <= 1'b0;
                    end
                end

                // A started fetch always runs to completion, even if the
                // enable drops meanwhile.
                ST_FETCH: begin
                    if (imem_ready) begin
                        state_q       <= ST_ISSUE;
                        instr_q       <= imem_rdata;
                        instr_valid_q <= 1'b1;
                        imem_req_q    <= 1'b0;
                    end
                end

                // Memory is ignored here; instr stays frozen until retire.
                ST_ISSUE: begin
                    if (instr_done) begin
                        pc_q          <= next_pc_d;
                        instr_valid_q <= 1'b0;
                        if (fetch_enable) begin
                            state_q     <= ST_FETCH;
                            imem_req_q  <= 1'b1;
                            imem_addr_q <= next_pc_d;
                        end else begin
                            state_q     <= ST_IDLE;
                            imem_req_q  <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q       <= ST_IDLE;
                    instr_valid_q <= 1'b0;
                    imem_req_q    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky illegal-select flag, only evaluated on an actual retire.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_sel_err_q <= 1'b0;
        end else if (retire && sel_bad_d) begin
            pc_sel_err_q <= 1'b1;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[18:13];
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign pc_sel_err  = pc_sel_err_q;

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: fetch_enable  input  1  permits new fetches.
REQ-004 SHALL have: imem_req  output  1  instruction memory read request.
REQ-005 SHALL have: imem_addr  output  12  word address of the request.
REQ-006 SHALL have: imem_ready  input  1  imem_rdata valid this cycle.
REQ-007 SHALL have: imem_rdata  input  19  instruction word from memory.
REQ-008 SHALL have: instr  output  19  issued instruction.
REQ-009 SHALL have: opcode  output  6  instr[18:13], drives decoder opcode input.
REQ-010 SHALL have: instr_valid  output  1  instr holds an unretired instruction.
REQ-011 SHALL have: instr_done  input  1  execute stage retires the issued instruction.
REQ-012 SHALL have: sel_PCSrc_plus1, sel_PCSrc_offset, sel_PCSrc_const  input  1 each  next-PC source from decoder.
REQ-013 SHALL have: branch_taken  input  1  conditional-jump condition result.
REQ-014 SHALL have: pc  output  12  address of current instruction.
REQ-015 SHALL have: pc_sel_err  output  1  sticky illegal-select flag.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, ISSUE.
REQ-017 IDLE: imem_req=0, instr_valid=0; -> FETCH when fetch_enable=1, else stay.
REQ-018 FETCH: imem_req=1, imem_addr=pc; on imem_ready=1 SHALL load imem_rdata into instr and go to ISSUE; else stay.
REQ-019 instr_valid SHALL assert the cycle after imem_ready is sampled (1-cycle capture latency).
REQ-020 fetch_enable deassert during FETCH SHALL NOT abort; outstanding fetch completes to ISSUE.
REQ-021 ISSUE: instr_valid=1, imem_req=0, instr stable; imem_ready ignored.
REQ-022 ISSUE with instr_done=1: pc <= next_pc; -> FETCH if fetch_enable=1, else IDLE; instr_valid=0 next cycle.
REQ-023 instr_done outside ISSUE SHALL be ignored.
REQ-024 next_pc, plus1 only: pc+1.
REQ-025 next_pc, offset only: branch_taken ? pc+1+sext(instr[7:0]) : pc+1.
REQ-026 next_pc, const only: instr[11:0].
REQ-027 Zero or more than one select asserted at retire: next_pc=pc+1 and pc_sel_err set; stays set until reset.
REQ-028 All PC arithmetic SHALL be 12-bit modulo 4096 (4095+1=0; 0+1+sext(0x80)=0xF81).
REQ-029 opcode SHALL be combinational from instr.
REQ-030 Peak throughput: one instruction per 2 cycles when imem_ready answers in the request cycle and instr_done arrives in the first ISSUE cycle.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, pc=0, instr=0, instr_valid=0, imem_req=0, imem_addr=0, pc_sel_err=0.
REQ-032 Reset during FETCH or ISSUE SHALL discard the in-flight instruction; first fetch after release is from address 0.
REQ-033 After rst falls, first transition out of IDLE SHALL occur on the first rising edge with fetch_enable=1.

Verification
REQ-034 Sequential: mem[0..3]=plus1 ops, ready same cycle, done in first ISSUE cycle -> imem_addr 0,1,2,3 on alternating cycles; pc=3 at fourth issue.
REQ-035 Branch: pc=0x010, instr[7:0]=0xFC, offset, branch_taken=1 -> pc=0x00D; same with branch_taken=0 -> pc=0x011.
REQ-036 Jump/wrap: const with instr[11:0]=0xFFF -> pc=0xFFF; next plus1 retire -> pc=0x000.
REQ-037 Memory wait: imem_ready held low 5 cycles in FETCH -> imem_req=1 and imem_addr constant throughout; instr_valid rises exactly 1 cycle after ready.
REQ-038 Errors/reset: retire with no select -> pc+1 and pc_sel_err=1; assert rst mid-ISSUE -> all outputs zero asynchronously, pc_sel_err cleared.
REQ-039 Enable: drop fetch_enable during FETCH -> fetch completes, retire, state IDLE, imem_req=0 until fetch_enable=1.
